// File: rtl/serial_pkg.sv
// Shared state encoding and constants for the oversampling serial receiver.
// Optional parity support is selected with the SERIAL_RX_PARITY_EN macro.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Synchronizer flops come out of reset at the idle line level.
    localparam logic SYNC_RESET = 1'b1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Receive FIFO with a registered head word; the head holds its last value
// when the FIFO drains so the consumer sees a stable q while empty.
module serial_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
        // The next head may be the word being written this very cycle.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/serial_rx_ovs.sv
// Oversampling serial receiver with majority-vote bit decisions and a receive
// FIFO. Define SERIAL_RX_PARITY_EN to add a parity bit, ODD and parity_err.
module serial_rx_ovs
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef SERIAL_RX_PARITY_EN
    ,
    parameter bit          ODD        = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 rd,
    output logic [WIDTH-1:0]     q,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(WIDTH);
    localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SAMP_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]           hist_q, hist_d;
    logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef SERIAL_RX_PARITY_EN
    logic                 parity_q, parity_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic tick;
    logic mid;
    logic decision;
    logic push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_valid;

    always_comb begin
        sync1_d    = rx;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q >= div);
        tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_WIDTH'(1);
        hist_d     = tick ? {hist_q[0], sync2_q} : hist_q;
        decision   = maj3({hist_q, sync2_q});
        // The sample counter only advances while a frame is in flight; the
        // decision tick is the one that brings it to OVERSAMPLE/2 of the bit.
        mid        = tick && (samp_cnt_q == SAMP_MID);
        samp_cnt_d = samp_cnt_q;
        if (tick && (state_q != ST_IDLE) && (state_q != ST_BREAK)) begin
            samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SCW'(1);
        end

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tick && !sync2_q) begin
                    state_d    = ST_START;
                    samp_cnt_d = '0;
                end
            end
            ST_START: begin
                if (mid) begin
                    state_d   = decision ? ST_IDLE : ST_DATA;
                    bit_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d = {decision, shift_q[WIDTH-1:1]};
`ifdef SERIAL_RX_PARITY_EN
                    parity_d = parity_q ^ decision;
`endif
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (mid) begin
                    parity_d = parity_q ^ decision;
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (mid) begin
                    if (decision) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        parity_err_d = (parity_q != ODD);
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (tick && sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fifo_pop  = rd && fifo_valid;
        overrun_d = push && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= SYNC_RESET;
            sync2_q      <= SYNC_RESET;
            tick_cnt_q   <= '0;
            hist_q       <= {2{SYNC_RESET}};
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            tick_cnt_q   <= tick_cnt_d;
            hist_q       <= hist_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    serial_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(shift_q),
        .pop  (fifo_pop),
        .rdata(q),
        .valid(fifo_valid),
        .full (fifo_full)
    );

    assign valid     = fifo_valid;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_ovs.sv
// Bench for serial_rx_ovs: a tick-indexed receiver model and FIFO queue are
// compared against the DUT every cycle. Honors SERIAL_RX_PARITY_EN.
module tb_serial_rx_ovs;

    localparam int W     = 8;
    localparam int OS    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam bit ODD   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int STOPB = W + 1 + PB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic [DW-1:0] div = '0;
    logic          rd;
    logic          rd_man = 1'b0;
    logic          rd_rand = 1'b0;
    logic          rnd_rd = 1'b0;
    logic [W-1:0]  q;
    logic          valid;
    logic          frame_err;
    logic          overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`endif

    assign rd = rnd_rd ? rd_rand : rd_man;

    serial_rx_ovs #(
        .WIDTH(W),
        .OVERSAMPLE(OS),
        .DIV_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .ODD(ODD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .div(div),
        .rd(rd),
        .q(q),
        .valid(valid),
        .frame_err(frame_err),
        .overrun(overrun)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference receiver state: ticks are numbered from the start-detection tick.
    int           pcount = 0;
    int           cyc = 0;
    int           n = 0;
    bit           m_s1 = 1'b1, m_s2 = 1'b1;
    bit           h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;
    bit           in_frame = 1'b0, brk = 1'b0;
    bit           mpar = 1'b0;
    logic [W-1:0] mdata = '0;
    logic [W-1:0] mq[$];
    logic [W-1:0] q_exp = '0;
    bit           fe_exp = 1'b0, ov_exp = 1'b0, pe_exp = 1'b0;
    int           fe_seen = 0, ov_seen = 0, pe_seen = 0;
    int           rise_idx = -1;
    bit           valid_prev = 1'b0;

    always @(posedge clk) begin : model
        bit srx, tk, d, att, par_bad;
        int b;
        pcount++;
        fe_exp = 1'b0;
        ov_exp = 1'b0;
        pe_exp = 1'b0;
        if (rst) begin
            mq.delete();
            q_exp = '0;
            m_s1 = 1'b1; m_s2 = 1'b1;
            h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
            in_frame = 1'b0; brk = 1'b0; mpar = 1'b0;
            cyc = 0; n = 0;
        end else begin
            srx = m_s2;
            tk = (cyc % (int'(div) + 1)) == int'(div);
            att = 1'b0;
            par_bad = 1'b0;
            if (tk) begin
                h0 = h1; h1 = h2; h2 = srx;
                if (brk) begin
                    if (srx) brk = 1'b0;
                end else if (!in_frame) begin
                    if (!srx) begin
                        in_frame = 1'b1; n = 0; mpar = 1'b0;
                    end
                end else begin
                    n++;
                    if (n % OS == OS / 2) begin
                        b = n / OS;
                        d = (int'(h0) + int'(h1) + int'(h2)) >= 2;
                        if (b == 0) begin
                            if (d) in_frame = 1'b0;
                        end else if (b <= W) begin
                            mdata[b-1] = d;
                            mpar ^= d;
                        end else if (b < STOPB) begin
                            mpar ^= d;
                        end else begin
                            in_frame = 1'b0;
                            if (d) begin
                                att = 1'b1;
                                par_bad = (mpar != ODD);
                            end else begin
                                fe_exp = 1'b1;
                                brk = 1'b1;
                            end
                        end
                    end
                end
            end
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (att) begin
                if (mq.size() < DEPTH) mq.push_back(mdata);
                else ov_exp = 1'b1;
            end
            pe_exp = att && par_bad;
            if (mq.size() > 0) q_exp = mq[0];
            m_s2 = m_s1;
            m_s1 = rx;
            cyc++;
        end
        #1;
        check("valid", 32'(valid), 32'(mq.size() > 0));
        check("q", 32'(q), 32'(q_exp));
        check("frame_err", 32'(frame_err), 32'(fe_exp));
        check("overrun", 32'(overrun), 32'(ov_exp));
`ifdef SERIAL_RX_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(pe_exp));
        if (parity_err) pe_seen++;
`endif
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        if (valid && !valid_prev) rise_idx = pcount;
        valid_prev = valid;
    end

    always @(negedge clk) rd_rand = ($urandom_range(0, 3) == 0);

    function automatic bit par(input logic [W-1:0] v);
        return (^v) ^ ODD;
    endfunction

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one frame; abort_at >= 0 pulses rst halfway through that bit slot.
    task automatic send(input logic [W-1:0] d, input bit stopb, input bit parb, input int abort_at);
        int bt;
        logic bits[$];
        bt = OS * (int'(div) + 1);
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (PB == 1) bits.push_back(parb);
        bits.push_back(stopb);
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            if (i == abort_at) begin
                repeat (bt / 2) @(negedge clk);
                rst = 1'b1;
                rx = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            repeat (bt) @(negedge clk);
        end
    endtask

    task automatic pop1();
        rd_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0;
    endtask

    initial begin : stim
        int bt, fall_idx, fe0, ov0;
        logic [W-1:0] d;
        bit stopb, parb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_q", 32'(q), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        idle(20);
        bt = OS * (int'(div) + 1);

        fall_idx = pcount;
        send(8'hA5, 1'b1, par(8'hA5), -1);
        idle(10);
        check("a5_latency", 32'(rise_idx), 32'(fall_idx + STOPB * OS + OS / 2 + 3));
        check("a5_q", 32'(q), 32'hA5);
        check("a5_valid", 32'(valid), 32'h1);
        pop1();
        check("hold_valid", 32'(valid), 32'h0);
        check("hold_q", 32'(q), 32'hA5);

        fe0 = fe_seen;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * bt);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_fe", 32'(fe_seen - fe0), 32'h0);
        send(8'h5A, 1'b1, par(8'h5A), -1);
        idle(bt);
        check("post_glitch_q", 32'(q), 32'h5A);
        pop1();

        fe0 = fe_seen;
        send(8'h3C, 1'b0, par(8'h3C), -1);
        repeat (20 * bt) @(negedge clk);
        check("break_fe_count", 32'(fe_seen - fe0), 32'h1);
        check("break_valid", 32'(valid), 32'h0);
        idle(2 * bt);
        send(8'h81, 1'b1, par(8'h81), -1);
        idle(bt);
        check("post_break_q", 32'(q), 32'h81);
        pop1();

        ov0 = ov_seen;
        for (int k = 1; k <= 5; k++) begin
            send(W'(k), 1'b1, par(W'(k)), -1);
            idle(bt);
        end
        check("overrun_count", 32'(ov_seen - ov0), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            check("overrun_pop_q", 32'(q), 32'(k));
            pop1();
        end
        check("overrun_drained", 32'(valid), 32'h0);

`ifdef SERIAL_RX_PARITY_EN
        begin
            int pe0;
            pe0 = pe_seen;
            send(8'h07, 1'b1, 1'b0, -1);
            idle(bt);
            check("parity_err_count", 32'(pe_seen - pe0), 32'h1);
            check("parity_q", 32'(q), 32'h07);
            pop1();
        end
`endif

        send(8'hC3, 1'b1, par(8'hC3), 5);
        check("abort_valid", 32'(valid), 32'h0);
        idle(2 * bt);
        send(8'h55, 1'b1, par(8'h55), -1);
        idle(bt);
        check("abort_next_q", 32'(q), 32'h55);
        pop1();

        for (int r = 0; r < 4; r++) begin
            rst = 1'b1;
            div = DW'($urandom_range(0, 3));
            repeat (2) @(negedge clk);
            rst = 1'b0;
            bt = OS * (int'(div) + 1);
            idle(bt);
            rnd_rd = 1'b1;
            for (int f = 0; f < 8; f++) begin
                d = W'($urandom);
                stopb = ($urandom_range(0, 7) != 0);
                parb = par(d) ^ ($urandom_range(0, 5) == 0);
                send(d, stopb, parb, -1);
                idle($urandom_range(bt, 2 * bt));
            end
            rnd_rd = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
